// File: rtl/csd2bin.sv
// Iterative CSD-to-two's-complement converter: folds one CSD digit per clock, MSD first.
// Optional canonical-form checking is enabled by defining CSD2BIN_CHECK_EN.
module csd2bin #(
    parameter int unsigned W = 5
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [2*W-1:0]   x,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [W-1:0]     y,
    output logic             ovf,
    output logic             err,
    output logic             y_valid,
    input  logic             y_ready
);

    localparam int unsigned AW = W + 1;
    localparam int unsigned XW = 2 * W;
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [XW-1:0] sr;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_nxt;
    logic [AW-1:0] d_ext;
    logic [1:0]    msd;
    logic [CW-1:0] cnt;
    logic          last_digit;

    assign msd        = sr[XW-1 -: 2];
    assign last_digit = (state == S_CONV) && (cnt == '0);

    // Sign-magnitude digit decode; the invalid code 10 contributes zero.
    always_comb begin
        d_ext = '0;
        case (msd)
            2'b01:   d_ext = AW'(1);
            2'b11:   d_ext = '1;
            default: d_ext = '0;
        endcase
        acc_nxt = {acc[W-1:0], 1'b0} + d_ext;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (x_valid && x_ready) state_nxt = S_CONV;
            S_CONV:  if (cnt == '0)          state_nxt = S_DONE;
            S_DONE:  if (y_ready)            state_nxt = S_IDLE;
            default:                         state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Handshake flags are registered copies of the upcoming state.
    always_ff @(posedge clk) begin
        if (srst) begin
            x_ready <= 1'b1;
            y_valid <= 1'b0;
            y       <= '0;
            ovf     <= 1'b0;
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            x_ready <= (state_nxt == S_IDLE);
            y_valid <= (state_nxt == S_DONE);
            if (state == S_IDLE && x_valid && x_ready) begin
                sr  <= x;
                acc <= '0;
                cnt <= CW'(W - 1);
            end else if (state == S_CONV) begin
                sr  <= {sr[XW-3:0], 2'b00};
                acc <= acc_nxt;
                cnt <= cnt - CW'(1);
            end
            // Result fits W bits only when the top two accumulator bits agree.
            if (last_digit) begin
                y   <= acc_nxt[W-1:0];
                ovf <= acc_nxt[W] ^ acc_nxt[W-1];
            end
        end
    end

`ifdef CSD2BIN_CHECK_EN
    logic prev_nz;
    logic err_acc;
    logic err_nxt;

    assign err_nxt = err_acc | (msd == 2'b10) | (prev_nz & msd[0]);

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_nz <= 1'b0;
            err_acc <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == S_IDLE && x_valid && x_ready) begin
                prev_nz <= 1'b0;
                err_acc <= 1'b0;
            end else if (state == S_CONV) begin
                prev_nz <= msd[0];
                err_acc <= err_nxt;
            end
            if (last_digit) err <= err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
